// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared scancodes, frame FSM states and key event type
package ps2_pkg;

  localparam logic [7:0] SC_EXT      = 8'hE0;
  localparam logic [7:0] SC_BREAK    = 8'hF0;
  localparam logic [7:0] SC_KP_PLUS  = 8'h79;
  localparam logic [7:0] SC_KP_MINUS = 8'h7B;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_evt_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 pin synchroniser, clock glitch filter and 11-bit frame receiver
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err
);

  localparam int             TCW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0]     FLT_LAST = 4'(FILTER_LEN - 1);
  localparam logic [TCW-1:0] TC_LAST  = TCW'(TIMEOUT_CYCLES - 1);
  localparam logic [TCW-1:0] TC_ONE   = TCW'(1);

  logic [2:0]     r_clk_sync;
  logic [2:0]     r_data_sync;
  logic           r_filt;
  logic           r_filt_d;
  logic [3:0]     r_fcnt;
  frame_state_t   r_state;
  frame_state_t   w_state_nxt;
  logic [2:0]     r_bit_idx;
  logic [2:0]     w_bit_idx_nxt;
  logic [7:0]     r_shift;
  logic [7:0]     w_shift_nxt;
  logic           r_parity;
  logic           w_parity_nxt;
  logic [TCW-1:0] r_tcnt;
  logic [TCW-1:0] w_tcnt_nxt;
  logic           r_byte_valid;
  logic           w_byte_valid_nxt;
  logic           w_fall;
  logic           w_data;
  logic           w_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
    end else begin
      r_clk_sync  <= {r_clk_sync[1:0], i_ps2_clk};
      r_data_sync <= {r_data_sync[1:0], i_ps2_data};
    end
  end

  // The filtered level only follows the pin after FILTER_LEN straight disagreeing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_filt   <= 1'b1;
      r_filt_d <= 1'b1;
      r_fcnt   <= '0;
    end else begin
      r_filt_d <= r_filt;
      if (r_clk_sync[2] == r_filt) begin
        r_fcnt <= '0;
      end else if (r_fcnt == FLT_LAST) begin
        r_fcnt <= '0;
        r_filt <= r_clk_sync[2];
      end else begin
        r_fcnt <= r_fcnt + 4'd1;
      end
    end
  end

  assign w_fall = r_filt_d & ~r_filt;
  assign w_data = r_data_sync[2];

  always_comb begin
    w_state_nxt      = r_state;
    w_bit_idx_nxt    = r_bit_idx;
    w_shift_nxt      = r_shift;
    w_parity_nxt     = r_parity;
    w_byte_valid_nxt = 1'b0;
    w_err            = 1'b0;
    w_tcnt_nxt       = (r_state == IDLE || w_fall) ? '0 : r_tcnt + TC_ONE;
    if (w_fall) begin
      case (r_state)
        IDLE: begin
          if (!w_data) begin
            w_state_nxt   = DATA;
            w_bit_idx_nxt = 3'd0;
          end else begin
            w_err = 1'b1;
          end
        end
        DATA: begin
          w_shift_nxt   = {w_data, r_shift[7:1]};
          w_bit_idx_nxt = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_state_nxt = PARITY;
        end
        PARITY: begin
          w_parity_nxt = w_data;
          w_state_nxt  = STOP;
        end
        STOP: begin
          w_state_nxt = IDLE;
          if (w_data && (^{r_shift, r_parity})) w_byte_valid_nxt = 1'b1;
          else                                  w_err            = 1'b1;
        end
        default: w_state_nxt = IDLE;
      endcase
    end else if (r_state != IDLE && r_tcnt == TC_LAST) begin
      // Reported in the cycle the counter would reach TIMEOUT_CYCLES.
      w_state_nxt = IDLE;
      w_tcnt_nxt  = '0;
      w_err       = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_parity     <= 1'b0;
      r_tcnt       <= '0;
      r_byte_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_bit_idx    <= w_bit_idx_nxt;
      r_shift      <= w_shift_nxt;
      r_parity     <= w_parity_nxt;
      r_tcnt       <= w_tcnt_nxt;
      r_byte_valid <= w_byte_valid_nxt;
    end
  end

  assign o_byte       = r_shift;
  assign o_byte_valid = r_byte_valid;
  assign o_frame_err  = w_err;

endmodule

// File: rtl/ps2_key_rx.sv
// rtl/ps2_key_rx.sv - PS/2 keyboard receiver: E0/F0 prefix decode into key events
// buffered in a show-ahead FIFO with valid/ready handshake
module ps2_key_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ps2_clk,
  input  logic                        ps2_data,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [7:0]                  evt_code,
  output logic                        evt_ext,
  output logic                        evt_break,
  output logic                        frame_err,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [7:0]    w_byte;
  logic          w_byte_valid;
  logic          w_frame_err;
  logic          r_ext;
  logic          r_brk;
  key_evt_t      r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;
  logic          w_push_req;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic          w_full;
  key_evt_t      w_head;

  ps2_frame_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk          (clk),
    .rst          (rst),
    .i_ps2_clk    (ps2_clk),
    .i_ps2_data   (ps2_data),
    .o_byte       (w_byte),
    .o_byte_valid (w_byte_valid),
    .o_frame_err  (w_frame_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (w_frame_err) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (w_byte_valid) begin
      if (w_byte == SC_EXT) begin
        r_ext <= 1'b1;
      end else if (w_byte == SC_BREAK) begin
        r_brk <= 1'b1;
      end else begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end
    end
  end

  assign w_push_req = w_byte_valid && (w_byte != SC_EXT) && (w_byte != SC_BREAK);
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_FULL);
  assign w_pop      = !w_empty && evt_ready;
  // A pop frees the slot in the same edge, so a full FIFO still takes the push.
  assign w_push     = w_push_req && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= key_evt_t'({r_ext, r_brk, w_byte});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_push_req && !w_push;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head     = r_mem[r_rd_ptr];
  assign evt_valid  = !w_empty;
  assign evt_code   = w_empty ? 8'h00 : w_head.code;
  assign evt_ext    = !w_empty && w_head.ext;
  assign evt_break  = !w_empty && w_head.brk;
  assign frame_err  = w_frame_err;
  assign overflow   = r_overflow;
  assign fifo_count = r_count;

endmodule

// File: tb/tb_ps2_key_rx.sv
// tb/tb_ps2_key_rx.sv - self-checking bench for ps2_key_rx against a frame-level event model
module tb_ps2_key_rx;

  localparam int F       = 4;
  localparam int T       = 200;
  localparam int D       = 8;
  localparam int HALF    = 10;
  localparam int LAT_EVT = 3 + F + 2;
  localparam int LAT_TO  = 3 + F + T;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic       ps2_clk   = 1'b1;
  logic       ps2_data  = 1'b1;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic       frame_err;
  logic       overflow;
  logic [3:0] fifo_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_fall_cyc = 0;
  int evt_rise_cyc  = -1;
  int err_cyc       = -1;
  int n_err = 0, n_ovf = 0, n_pops = 0, n_valid_hi = 0;
  int exp_err = 0, exp_ovf = 0;
  logic prev_valid = 1'b0;
  bit   rand_ready = 1'b0;
  logic m_ext = 1'b0, m_brk = 1'b0;
  logic [9:0] exp_q[$];

  ps2_key_rx #(
    .FILTER_LEN     (F),
    .TIMEOUT_CYCLES (T),
    .FIFO_DEPTH     (D)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_code   (evt_code),
    .evt_ext    (evt_ext),
    .evt_break  (evt_break),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (frame_err) begin n_err++; err_cyc = cyc; end
      if (overflow) n_ovf++;
      if (evt_valid) n_valid_hi++;
      if (evt_valid && !prev_valid) evt_rise_cyc = cyc;
      if (evt_valid && evt_ready) begin
        n_pops++;
        if (exp_q.size() == 0) check_eq("evt_unexpected_qsize", 32'(exp_q.size()), 32'd1);
        else check_eq("evt_head", {22'd0, evt_ext, evt_break, evt_code}, {22'd0, exp_q.pop_front()});
      end
      prev_valid = evt_valid;
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      evt_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit pulse_rdy);
    ps2_data = b;
    tick(HALF);
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    if (pulse_rdy) begin
      tick(3 + F + 1);
      evt_ready = 1'b1;
      tick(1);
      evt_ready = 1'b0;
      tick(HALF - (3 + F + 2));
    end else begin
      tick(HALF);
    end
    ps2_clk = 1'b1;
  endtask

  // Expected outcome of one complete frame: error, prefix, or a pushed/dropped event.
  task automatic model_frame(input logic [7:0] b, input bit ok, input bit pop_same);
    if (!ok) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
      exp_err++;
      return;
    end
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      if (exp_q.size() >= D && !pop_same) exp_ovf++;
      else exp_q.push_back({m_ext, m_brk, b});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit pulse_rdy);
    logic p;
    p = (~^b) ^ bad_par;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
    send_bit(p, 1'b0);
    model_frame(b, !bad_par && !bad_stop, pulse_rdy);
    send_bit(!bad_stop, pulse_rdy);
    ps2_data = 1'b1;
    tick(HALF);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_evt_valid"}, 32'(evt_valid), 32'd0);
    check_eq({tag, "_fifo_count"}, 32'(fifo_count), 32'd0);
    check_eq({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    check_eq({tag, "_overflow"}, 32'(overflow), 32'd0);
    check_eq({tag, "_evt_code"}, 32'({evt_ext, evt_break, evt_code}), 32'd0);
  endtask

  initial begin
    int e0, o0, p0;
    logic [7:0] b;
    int kind;

    tick(3);
    check_idle_outputs("reset");
    rst = 1'b0;
    tick(5);

    evt_ready = 1'b1;
    n_valid_hi = 0;
    evt_rise_cyc = -1;
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    check_eq("evt_latency", 32'(evt_rise_cyc - last_fall_cyc), 32'(LAT_EVT));
    check_eq("evt_valid_width", 32'(n_valid_hi), 32'd1);
    check_eq("q_after_1c", 32'(exp_q.size()), 32'd0);

    p0 = n_pops;
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0, 1'b0);
    check_eq("prefix_seq_pops", 32'(n_pops - p0), 32'd3);

    e0 = n_err;
    p0 = n_pops;
    send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
    check_eq("parity_err_pulse", 32'(n_err - e0), 32'd1);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    check_eq("after_parity_pops", 32'(n_pops - p0), 32'd1);

    e0 = n_err;
    ps2_clk = 1'b0;
    tick(F - 1);
    ps2_clk = 1'b1;
    tick(20);
    check_eq("glitch_no_err", 32'(n_err - e0), 32'd0);
    send_frame(8'h33, 1'b0, 1'b0, 1'b0);

    send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
    e0 = n_err;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    m_ext = 1'b0;
    m_brk = 1'b0;
    exp_err++;
    tick(LAT_TO + 20);
    check_eq("timeout_err_pulse", 32'(n_err - e0), 32'd1);
    check_eq("timeout_latency", 32'(err_cyc - last_fall_cyc), 32'(LAT_TO));
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    check_eq("q_after_timeout", 32'(exp_q.size()), 32'd0);

    evt_ready = 1'b0;
    o0 = n_ovf;
    for (int i = 0; i < D + 1; i++) send_frame(8'($urandom_range(0, 8'hDF)), 1'b0, 1'b0, 1'b0);
    check_eq("full_count", 32'(fifo_count), 32'(D));
    check_eq("overflow_pulses", 32'(n_ovf - o0), 32'd1);
    send_frame(8'($urandom_range(0, 8'hDF)), 1'b0, 1'b0, 1'b1);
    check_eq("full_push_pop_count", 32'(fifo_count), 32'(D));
    check_eq("full_push_pop_no_ovf", 32'(n_ovf - o0), 32'd1);
    evt_ready = 1'b1;
    tick(20);
    check_eq("drain_count", 32'(fifo_count), 32'd0);
    check_eq("drain_q", 32'(exp_q.size()), 32'd0);

    evt_ready = 1'b0;
    rand_ready = 1'b1;
    for (int i = 0; i < 25; i++) begin
      kind = $urandom_range(0, 9);
      if (kind < 2) b = 8'hE0;
      else if (kind == 2) b = 8'hF0;
      else b = 8'($urandom_range(0, 255));
      send_frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0, 1'b0);
    end
    rand_ready = 1'b0;
    tick(2);
    evt_ready = 1'b1;
    tick(20);
    check_eq("rand_q_empty", 32'(exp_q.size()), 32'd0);
    check_eq("rand_fifo_empty", 32'(fifo_count), 32'd0);

    evt_ready = 1'b0;
    send_frame(8'h16, 1'b0, 1'b0, 1'b0);
    send_frame(8'h1E, 1'b0, 1'b0, 1'b0);
    check_eq("pre_reset_count", 32'(fifo_count), 32'd2);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    exp_q.delete();
    m_ext = 1'b0;
    m_brk = 1'b0;
    ps2_data = 1'b1;
    ps2_clk = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(30);
    evt_ready = 1'b1;
    p0 = n_pops;
    send_frame(8'h79, 1'b0, 1'b0, 1'b0);
    check_eq("post_reset_pops", 32'(n_pops - p0), 32'd1);
    check_eq("post_reset_q", 32'(exp_q.size()), 32'd0);

    check_eq("total_frame_err", 32'(n_err), 32'(exp_err));
    check_eq("total_overflow", 32'(n_ovf), 32'(exp_ovf));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
